mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF stage (instruction fetch, read-only)
//  and the MEM stage (load/store). Serialises requests, drives the memory handshake, returns

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between IF fetches and MEM loads/stores
// MEM wins ties as the older instruction; a streak limit forces an IF grant to prevent starvation.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t            state, state_nx;
  owner_t            owner;
  logic [SW-1:0]     streak;
  logic [TW-1:0]     wait_cnt;
  logic              force_if, grant_mem, grant_if, timeout_hit, done;
  logic [DATA_W-1:0] cap_data;

  assign force_if    = if_req && (streak == SW'(STARVE_MAX));
  assign grant_mem   = mem_req && !force_if;
  assign grant_if    = if_req && !grant_mem;
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));
  assign done        = m_ready || timeout_hit;
  // A late m_ready on the last allowed cycle still counts as a real completion.
  assign cap_data    = m_ready ? m_rdata : '0;

  assign m_en      = (state == BUSY);
  assign if_valid  = (state == RESP) && (owner == OWN_IF);
  assign mem_valid = (state == RESP) && (owner == OWN_MEM);
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = mem_req & ~mem_valid;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (if_req || mem_req) state_nx = BUSY;
      BUSY:    if (done) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      streak    <= '0;
      wait_cnt  <= '0;
      err       <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (!if_req) streak <= '0;
          if (grant_mem) begin
            owner   <= OWN_MEM;
            m_we    <= mem_we;
            m_addr  <= mem_addr;
            m_wdata <= mem_wdata;
            if (if_req && streak != SW'(STARVE_MAX)) streak <= streak + 1'b1;
          end else if (grant_if) begin
            owner   <= OWN_IF;
            m_we    <= 1'b0;
            m_addr  <= if_addr;
            m_wdata <= '0;
            streak  <= '0;
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (done) begin
            if (!m_ready) err <= 1'b1;
            if (owner == OWN_IF) if_rdata <= cap_data;
            else if (!m_we)      mem_rdata <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction model
// The bench plays the memory itself; the model tracks the one outstanding transaction and the grant rule.
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 15;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, m_ready = 1'b0;
  logic [15:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, m_rdata = '0;
  logic        if_valid, mem_valid, stall_if, stall_mem, m_en, m_we, err;
  logic [15:0] if_rdata, mem_rdata, m_addr, m_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          is_if;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        cur;
  bit          in_flight = 0, responding = 0, exp_err = 0;
  int          elapsed = 0, lat = 0, lat_force = -1, streak_m = 0;
  logic [15:0] exp_if_rdata = '0, exp_mem_rdata = '0;
  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] grant_log [$];

  bit          s_if_valid, s_mem_valid, s_m_en, s_m_we, s_err, s_stall_if, prev_m_en = 0;
  logic [15:0] s_if_rdata, s_mem_rdata, s_m_wdata;

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 16'h5A5A);
  endfunction

  function automatic int pick_lat();
    int r;
    if (lat_force >= 0) return lat_force;
    r = $urandom_range(0, 19);
    if (r < 15) return r % 4;
    if (r < 17) return TIMEOUT - 1;
    if (r == 17) return TIMEOUT - 2;
    return 40;
  endfunction

  task automatic complete(input logic [15:0] d, input bit to);
    if (cur.is_if) exp_if_rdata = d;
    else if (!cur.we) exp_mem_rdata = d;
    if (to) exp_err = 1'b1;
    in_flight  = 0;
    responding = 1;
  endtask

  // One clock cycle: play memory, compare DUT outputs to the model, advance the model across the edge.
  task automatic step();
    if (in_flight) begin
      m_ready = (elapsed == lat);
      m_rdata = m_ready ? rd(cur.addr) : 16'($urandom);
    end else begin
      m_ready = 1'($urandom_range(0, 1));
      m_rdata = 16'($urandom);
    end
    #1;
    chk("m_en", m_en, in_flight);
    if (in_flight) begin
      chk("m_we", m_we, cur.we);
      chk("m_addr", m_addr, cur.addr);
      chk("m_wdata", m_wdata, cur.wdata);
    end
    chk("if_valid", if_valid, responding && cur.is_if);
    chk("mem_valid", mem_valid, responding && !cur.is_if);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("mem_rdata", mem_rdata, exp_mem_rdata);
    chk("err", err, exp_err);
    chk("stall_if", stall_if, if_req && !(responding && cur.is_if));
    chk("stall_mem", stall_mem, mem_req && !(responding && !cur.is_if));
    chk("two_valids", if_valid & mem_valid, 0);
    s_if_valid = if_valid;  s_mem_valid = mem_valid; s_m_en = m_en; s_m_we = m_we;
    s_err = err; s_stall_if = stall_if; s_if_rdata = if_rdata; s_mem_rdata = mem_rdata;
    s_m_wdata = m_wdata;
    if (m_en && !prev_m_en) grant_log.push_back(m_addr);
    prev_m_en = m_en;

    if (responding) begin
      responding = 0;
    end else if (in_flight) begin
      if (elapsed == lat) begin
        complete(rd(cur.addr), 1'b0);
        if (cur.we) mem_model[cur.addr] = cur.wdata;
      end else if (elapsed + 1 == TIMEOUT) begin
        complete(16'h0000, 1'b1);
      end else begin
        elapsed++;
      end
    end else begin
      if (!if_req) streak_m = 0;
      if (mem_req && !(if_req && streak_m == STARVE_MAX)) begin
        cur = '{is_if: 1'b0, we: mem_we, addr: mem_addr, wdata: mem_wdata};
        if (if_req) streak_m = (streak_m + 1 > STARVE_MAX) ? STARVE_MAX : streak_m + 1;
        in_flight = 1; elapsed = 0; lat = pick_lat();
      end else if (if_req) begin
        cur = '{is_if: 1'b1, we: 1'b0, addr: if_addr, wdata: 16'h0000};
        streak_m = 0;
        in_flight = 1; elapsed = 0; lat = pick_lat();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input bit want_if, input int maxc, output bit got);
    got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      got = want_if ? s_if_valid : s_mem_valid;
    end
  endtask

  initial begin
    bit got, if_busy, mem_busy;
    int cnt, pulses;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_en", m_en, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_wdata", m_wdata, 0);
    rst_n = 1'b1;

    // Fetch with one wait cycle: valid three cycles after the request is sampled.
    mem_model[16'h0010] = 16'hABCD;
    if_req = 1'b1; if_addr = 16'h0010; lat_force = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_valid", s_if_valid, k == 3);
      chk("t1_stall", s_stall_if, k != 3);
    end
    chk("t1_rdata", s_if_rdata, 16'hABCD);
    if_req = 1'b0;
    step();

    // Store then load back the same address.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h1234; lat_force = 0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_m_en) begin
        chk("t2_m_we", s_m_we, 1);
        chk("t2_m_wdata", s_m_wdata, 16'h1234);
      end
      if (s_mem_valid) begin pulses++; mem_req = 1'b0; end
    end
    chk("t2_pulses", pulses, 1);
    chk("t2_rdata_kept", s_mem_rdata, 16'h0000);
    mem_req = 1'b1; mem_we = 1'b0;
    run_until(1'b0, 10, got);
    chk("t2_load_done", got, 1);
    chk("t2_load_rdata", s_mem_rdata, 16'h1234);
    mem_req = 1'b0;
    step();

    // Both stages requesting continuously: four MEM grants then one forced IF grant.
    grant_log.delete();
    if_addr = 16'h0100; mem_addr = 16'h0200; mem_we = 1'b0;
    if_req = 1'b1; mem_req = 1'b1;
    repeat (30) step();
    if_req = 1'b0; mem_req = 1'b0;
    chk("t3_grants", grant_log.size() >= 10, 1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      chk($sformatf("t3_order%0d", i), grant_log[i], (i % 5 == 4) ? 16'h0100 : 16'h0200);
    step();

    // Memory never answers: abort after TIMEOUT busy cycles, err sticks.
    mem_model[16'h0030] = 16'hBEEF;
    mem_req = 1'b1; mem_addr = 16'h0030; lat_force = 99;
    cnt = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (s_m_en) cnt++;
      got = s_mem_valid;
    end
    chk("t4_done", got, 1);
    chk("t4_busy_cycles", cnt, TIMEOUT);
    chk("t4_rdata", s_mem_rdata, 16'h0000);
    chk("t4_err", s_err, 1);
    mem_req = 1'b0;
    step();
    if_req = 1'b1; if_addr = 16'h0010; lat_force = 0;
    run_until(1'b1, 10, got);
    chk("t4_next_done", got, 1);
    chk("t4_next_rdata", s_if_rdata, 16'hABCD);
    chk("t4_err_sticky", s_err, 1);
    if_req = 1'b0;
    step();

    // Reset in the middle of a transaction.
    mem_model[16'h0040] = 16'h4242;
    if_req = 1'b1; if_addr = 16'h0040; lat_force = 99;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("t5_m_en", m_en, 0);
    chk("t5_if_valid", if_valid, 0);
    chk("t5_err", err, 0);
    in_flight = 0; responding = 0; streak_m = 0; exp_err = 0;
    exp_if_rdata = '0; exp_mem_rdata = '0; prev_m_en = 0;
    @(posedge clk);
    #1;
    chk("t5_hold", m_en, 0);
    rst_n = 1'b1; lat_force = 0;
    grant_log.delete();
    run_until(1'b1, 10, got);
    chk("t5_served", got, 1);
    chk("t5_rdata", s_if_rdata, 16'h4242);
    chk("t5_grant", grant_log.size() > 0 ? grant_log[0] : 16'hFFFF, 16'h0040);
    if_req = 1'b0;
    step();

    // Random traffic; owner inputs scrambled mid-transaction to show they are latched.
    lat_force = -1;
    for (int c = 0; c < 3000; c++) begin
      if_busy  = (in_flight || responding) && cur.is_if;
      mem_busy = (in_flight || responding) && !cur.is_if;
      if (if_busy) if_addr = 16'($urandom);
      else if ($urandom_range(0, 3) == 0) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = 16'($urandom_range(0, 15));
      end
      if (mem_busy) begin
        mem_addr = 16'($urandom); mem_wdata = 16'($urandom); mem_we = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 3) == 0) begin
        mem_req   = 1'($urandom_range(0, 1));
        mem_we    = 1'($urandom_range(0, 1));
        mem_addr  = 16'($urandom_range(0, 15));
        mem_wdata = 16'($urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
